// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one ALU between two requesters (e.g. main pipeline and the
//   branch/address unit). Round-robin arbitration, one op in flight at a time.
//   The winning op is issued with a one-cycle alu_start pulse. ctrl_command is
//   held for the op's latency and keeps its last value between ops. A completion
//   token is then returned to the winner over a done_valid/done_ack handshake.
//
//   Opcodes: ADD=0 SUB=1 MUL=2 AND=3 OR=4. Anything above 4 is illegal. It is
//   not issued to the ALU, but it still completes with illegal_op=1.
//
// Parameters
//   MUL_CYCLES  ALU cycles for MUL, counted from the start cycle (1..15)
//   OPW         opcode / ctrl_command width
//
// Ports
//   clk, rst             rising-edge clock, async active-high reset
//   req0_valid/op/ready  requester 0 (ready is combinational)
//   req1_valid/op/ready  requester 1 (ready is combinational)
//   ctrl_command         opcode to ALU (registered)
//   alu_start            one-cycle start pulse (registered)
//   busy                 arbiter not idle (registered)
//   done_valid/done_id   completion token and its owner (registered)
//   illegal_op           completion was for an illegal opcode
//   done_ack             owner consumes the completion
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a request; the only state that accepts an op
// EXEC     | op issued to ALU (alu_start high if the op is legal)
// MUL_WAIT | multi-cycle MUL in progress; wait_cnt counts down to 0
// RESP     | completion presented; held until done_ack

module alu_issue_arbiter #(
  parameter int MUL_CYCLES = 3,
  parameter int OPW        = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  output logic           req1_ready,
  output logic [OPW-1:0] ctrl_command,
  output logic           alu_start,
  output logic           busy,
  output logic           done_valid,
  output logic           done_id,
  output logic           illegal_op,
  input  logic           done_ack
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_MUL_WAIT = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
  localparam logic [OPW-1:0] OP_LAST = OPW'(4);

  // EXEC is the first MUL cycle and RESP follows the cycle in which the
  // counter reads zero, so the counter is loaded with MUL_CYCLES-2.
  localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;
  localparam logic       MUL_MULTI = (MUL_CYCLES > 1);

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [OPW-1:0] op_q;
  logic           id_q;
  logic           illegal_q;
  logic           last_grant;
  logic [3:0]     wait_cnt;

  logic           winner;
  logic           accept;
  logic [OPW-1:0] winner_op;
  logic           winner_legal;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant;
    else if (req1_valid)          winner = 1'b1;
  end

  assign accept       = (state == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready   = accept && !winner;
  assign req1_ready   = accept && winner;
  assign winner_op    = winner ? req1_op : req0_op;
  assign winner_legal = (winner_op <= OP_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_EXEC;
      S_EXEC: begin
        if (!illegal_q && (op_q == OP_MUL) && MUL_MULTI) state_nxt = S_MUL_WAIT;
        else                                             state_nxt = S_RESP;
      end
      S_MUL_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:     if (done_ack) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
      alu_start    <= 1'b0;
      ctrl_command <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      illegal_q    <= 1'b0;
      last_grant   <= 1'b1;
      wait_cnt     <= 4'd0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      done_valid <= (state_nxt == S_RESP);
      // Registered outputs take their EXEC values on the accepting edge so
      // that alu_start and ctrl_command appear in the EXEC cycle itself.
      alu_start  <= accept && winner_legal;

      if (accept) begin
        op_q       <= winner_op;
        id_q       <= winner;
        illegal_q  <= !winner_legal;
        last_grant <= winner;
        // Illegal ops leave the ALU command untouched.
        if (winner_legal) ctrl_command <= winner_op;
      end

      if (state == S_EXEC)                             wait_cnt <= MUL_LOAD;
      else if (state == S_MUL_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign done_id    = id_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, done_ack;
  logic [3:0] req0_op, req1_op;

  logic       req0_ready, req1_ready, alu_start, busy, done_valid, done_id, illegal_op;
  logic [3:0] ctrl_command;

  logic       b_req0_ready, b_req1_ready, b_alu_start, b_busy, b_done_valid, b_done_id, b_illegal_op;
  logic [3:0] b_ctrl_command;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.MUL_CYCLES(3), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
    .ctrl_command(ctrl_command), .alu_start(alu_start), .busy(busy),
    .done_valid(done_valid), .done_id(done_id), .illegal_op(illegal_op),
    .done_ack(done_ack)
  );

  alu_issue_arbiter #(.MUL_CYCLES(1), .OPW(4)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(b_req1_ready),
    .ctrl_command(b_ctrl_command), .alu_start(b_alu_start), .busy(b_busy),
    .done_valid(b_done_valid), .done_id(b_done_id), .illegal_op(b_illegal_op),
    .done_ack(done_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_first;
    logic       r0v;
    logic [3:0] r0op;
    logic       r1v;
    logic [3:0] r1op;
    logic       ack;
    logic       e_r0rdy;
    logic       e_r1rdy;
    logic       e_start;
    logic [3:0] e_cmd;
    logic       e_busy;
    logic       e_dv;
    logic       e_id;
    logic       e_ill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rf, logic r0v, logic [3:0] r0op, logic r1v, logic [3:0] r1op,
                              logic ack, logic r0rdy, logic r1rdy, logic st, logic [3:0] cmd,
                              logic bsy, logic dv, logic id, logic ill);
    vec_t v;
    v.rst_first = rf; v.r0v = r0v; v.r0op = r0op; v.r1v = r1v; v.r1op = r1op; v.ack = ack;
    v.e_r0rdy = r0rdy; v.e_r1rdy = r1rdy; v.e_start = st; v.e_cmd = cmd;
    v.e_busy = bsy; v.e_dv = dv; v.e_id = id; v.e_ill = ill;
    return v;
  endfunction

  task automatic drive(input logic r0v, input logic [3:0] r0op, input logic r1v,
                       input logic [3:0] r1op, input logic ack);
    req0_valid = r0v; req0_op = r0op; req1_valid = r1v; req1_op = r1op; done_ack = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " alu_start"},    alu_start,    1'b0);
    chk({tag, " ctrl_command"}, ctrl_command, 4'd0);
    chk({tag, " busy"},         busy,         1'b0);
    chk({tag, " done_valid"},   done_valid,   1'b0);
    chk({tag, " done_id"},      done_id,      1'b0);
    chk({tag, " illegal_op"},   illegal_op,   1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    //        rf r0v op r1v op ack | r0r r1r st cmd bsy dv id ill
    // single ADD from req0, ack in first RESP cycle
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    // both requesting SUB continuously, immediate ack: grants 0,1,0,1
    tbl.push_back(mk(1, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1,  0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1, 1, 0));
    // illegal op 7 from req0: no start, command unchanged, flagged completion
    tbl.push_back(mk(0, 1, 7, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    // legal AND from req1 afterwards clears the flag and updates the command
    tbl.push_back(mk(0, 0, 0, 1, 3, 0,  0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 0, 0, 0));

    // reset values while reset is held
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      @(negedge clk);
      drive(tbl[i].r0v, tbl[i].r0op, tbl[i].r1v, tbl[i].r1op, tbl[i].ack);
      #1;
      chk($sformatf("vec%0d req0_ready", i),   req0_ready,   tbl[i].e_r0rdy);
      chk($sformatf("vec%0d req1_ready", i),   req1_ready,   tbl[i].e_r1rdy);
      chk($sformatf("vec%0d both_ready", i),   req0_ready & req1_ready, 1'b0);
      chk($sformatf("vec%0d alu_start", i),    alu_start,    tbl[i].e_start);
      chk($sformatf("vec%0d ctrl_command", i), ctrl_command, tbl[i].e_cmd);
      chk($sformatf("vec%0d busy", i),         busy,         tbl[i].e_busy);
      chk($sformatf("vec%0d done_valid", i),   done_valid,   tbl[i].e_dv);
      if (tbl[i].e_dv) begin
        chk($sformatf("vec%0d done_id", i),    done_id,      tbl[i].e_id);
        chk($sformatf("vec%0d illegal_op", i), illegal_op,   tbl[i].e_ill);
      end
    end

    // MUL from req1: MUL_CYCLES=3 on dut, MUL_CYCLES=1 on dut1
    do_reset();
    @(negedge clk);
    drive(0, 0, 1, 2, 0);
    #1;
    chk("mul accept req1_ready", req1_ready, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, (k == 4));
      #1;
      chk($sformatf("mul T+%0d alu_start", k),    alu_start,    (k == 1));
      chk($sformatf("mul T+%0d ctrl_command", k), ctrl_command, 4'd2);
      chk($sformatf("mul T+%0d done_valid", k),   done_valid,   (k == 4));
      chk($sformatf("mul1 T+%0d done_valid", k),  b_done_valid, (k >= 2));
      if (k == 4) chk("mul T+4 done_id", done_id, 1'b1);
      if (k == 2) chk("mul1 T+2 done_id", b_done_id, 1'b1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("mul after ack busy",  busy,   1'b0);
    chk("mul1 after ack busy", b_busy, 1'b0);

    // Delayed ack with req1 waiting: req1 shut out until the cycle after ack
    @(negedge clk);
    drive(1, 0, 1, 3, 0);
    #1;
    chk("hold tie req0_ready", req0_ready, 1'b1);
    chk("hold tie req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    drive(0, 0, 1, 3, 0);
    #1;
    chk("hold exec req1_ready", req1_ready, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 3, (k == 5));
      #1;
      chk($sformatf("hold resp%0d done_valid", k), done_valid, 1'b1);
      chk($sformatf("hold resp%0d req1_ready", k), req1_ready, 1'b0);
    end
    @(negedge clk);
    drive(0, 0, 1, 3, 0);
    #1;
    chk("hold post-ack done_valid", done_valid, 1'b0);
    chk("hold post-ack req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("hold exec2 alu_start",    alu_start,    1'b1);
    chk("hold exec2 ctrl_command", ctrl_command, 4'd3);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);

    // Reset during MUL_WAIT: req0 MUL so last_grant=0 before reset
    @(negedge clk);
    drive(1, 2, 0, 0, 0);
    #1;
    chk("rstmul accept req0_ready", req0_ready, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("rstmul in wait busy",       busy,       1'b1);
    chk("rstmul in wait done_valid", done_valid, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rstmul");
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstmul idle%0d done_valid", k), done_valid, 1'b0);
    end
    @(negedge clk);
    drive(1, 0, 1, 0, 0);
    #1;
    chk("rstmul tie req0_ready", req0_ready, 1'b1);
    chk("rstmul tie req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
